// File: rtl/gate_array_pipe.sv
// rtl/gate_array_pipe.sv - registered WIDTH-bit bitwise logic unit with stream handshakes and packet accumulate
// Output side is a main register plus a one-entry skid register so in_ready never depends on out_ready.

module gate_array_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam int EW = WIDTH + 2;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;

  // Buffer entries carry {ones, zero, y} so the flags travel with the data.
  logic          main_vld_q, main_vld_d;
  logic [EW-1:0] main_q, main_d;
  logic          skid_vld_q, skid_vld_d;
  logic [EW-1:0] skid_q, skid_d;

  logic             accept;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] res_y;
  logic [EW-1:0]    new_entry;

  assign in_ready = !rst && !skid_vld_q;
  assign accept   = in_valid && in_ready;
  assign pop      = main_vld_q && out_ready;

  assign out_valid = main_vld_q;
  assign out_y     = main_q[WIDTH-1:0];
  assign out_zero  = main_q[WIDTH];
  assign out_ones  = main_q[WIDTH+1];

  always_comb begin
    res_y = '0;
    if (state_q == ST_ACC) begin
      res_y = apply_op(op_q, acc_q, in_a);
    end else begin
      res_y = apply_op(in_op, in_a, in_b);
    end
  end

  assign new_entry = {(&res_y), (res_y == '0), res_y};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    push    = 1'b0;
    if (accept) begin
      if (state_q == ST_ACC) begin
        acc_d = res_y;
        if (in_last) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end else if (in_acc) begin
        // A packet opening without in_first is still treated as its first beat.
        acc_d = res_y;
        op_d  = in_op;
        if (in_last) begin
          push = 1'b1;
        end else begin
          state_d = ST_ACC;
        end
      end else begin
        push = 1'b1;
      end
    end
  end

  // A push never coincides with a full skid, because in_ready is low then.
  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (pop) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = push;
        skid_d     = push ? new_entry : '0;
      end else begin
        main_vld_d = push;
        main_d     = push ? new_entry : '0;
      end
    end else if (push) begin
      if (!main_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = new_entry;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = new_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      op_q       <= '0;
      main_vld_q <= 1'b0;
      main_q     <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      main_vld_q <= main_vld_d;
      main_q     <= main_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_gate_array_pipe.sv
// tb/tb_gate_array_pipe.sv - scoreboard bench for gate_array_pipe with a truth-table reference model
module tb_gate_array_pipe;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic [2:0]   in_op = 3'd0;
  logic         in_acc = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_y;
  logic         out_zero;
  logic         out_ones;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] in_a1 = '0;
  logic [0:0] in_b1 = '0;
  logic       out_valid1;
  logic [0:0] out_y1;
  logic       out_zero1;
  logic       out_ones1;

  gate_array_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_op(in_op), .in_acc(in_acc), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_ones(out_ones)
  );

  gate_array_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_first(1'b0), .in_last(1'b0),
    .in_op(3'd3), .in_acc(1'b0), .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_y(out_y1),
    .out_zero(out_zero1), .out_ones(out_ones1)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   tt [8];
  logic         m_pkt = 1'b0;
  logic [W-1:0] m_acc = '0;
  logic [2:0]   m_op = '0;
  int           rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Each op is a 2-input truth table indexed by {x_bit, y_bit}.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = tt[op];
    for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_y), 32'hdead);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("out_y", 32'(out_y), 32'(e));
          check("out_zero", 32'(out_zero), 32'(e == '0));
          check("out_ones", 32'(out_ones), 32'(e == '1));
        end
      end else if (!out_valid) begin
        check("flags_idle", {30'd0, out_zero, out_ones}, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic acc, input logic first, input logic last,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    logic accepted;
    int   guard;
    in_op = op; in_acc = acc; in_first = first; in_last = last; in_a = a; in_b = b;
    in_valid = 1'b1;
    accepted = 1'b0;
    guard = 0;
    while (!accepted && guard < 200) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      guard++;
    end
    #1;
    in_valid = 1'b0;
    if (!accepted) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (!m_pkt && !acc) begin
      exp_q.push_back(ref_op(op, a, b));
    end else if (!m_pkt) begin
      m_acc = ref_op(op, a, b);
      m_op  = op;
      if (last) exp_q.push_back(m_acc);
      else m_pkt = 1'b1;
    end else begin
      m_acc = ref_op(m_op, m_acc, a);
      if (last) begin
        exp_q.push_back(m_acc);
        m_pkt = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    idle(2);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] nor1;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
    tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
    nor1 = 4'b0001;

    rst = 1'b1;
    idle(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_flags", {30'd0, out_zero, out_ones}, 32'd0);
    rst = 1'b0;
    idle(1);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    for (int ab = 0; ab < 4; ab++) begin
      in_a1 = ab[1]; in_b1 = ab[0]; in_valid1 = 1'b1;
      idle(1);
      in_valid1 = 1'b0;
      check("w1_valid", 32'(out_valid1), 32'd1);
      check("w1_nor", 32'(out_y1), 32'(nor1[ab]));
    end

    rdy_mode = 1;
    idle(2);
    send(3'd3, 1'b0, 1'b0, 1'b0, 4'h5, 4'h3);
    check("latency1", 32'(out_valid), 32'd1);
    send(3'd3, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check("latency1_b", 32'(out_valid), 32'd1);
    drain();

    rdy_mode = 0;
    idle(2);
    send(3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h1);
    send(3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h2);
    check("skid_backpressure", 32'(in_ready), 32'd0);
    idle(3);
    check("held_y", 32'(out_y), 32'h1);
    rdy_mode = 1;
    send(3'd0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4);
    drain();

    send(3'd4, 1'b1, 1'b1, 1'b0, 4'h1, 4'h2);
    send(3'd4, 1'b1, 1'b0, 1'b0, 4'h4, 4'h9);
    send(3'd4, 1'b1, 1'b0, 1'b1, 4'h8, 4'h0);
    drain();

    send(3'd4, 1'b1, 1'b1, 1'b0, 4'h3, 4'h5);
    send(3'd0, 1'b1, 1'b0, 1'b0, 4'h9, 4'hF);
    send(3'd4, 1'b1, 1'b0, 1'b1, 4'h1, 4'h0);
    drain();

    send(3'd4, 1'b1, 1'b1, 1'b0, 4'h1, 4'h2);
    send(3'd4, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0);
    idle(3);
    rst = 1'b1;
    m_pkt = 1'b0;
    idle(2);
    check("midpkt_rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    idle(1);
    send(3'd4, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0);
    drain();

    send(3'd2, 1'b1, 1'b1, 1'b1, 4'hC, 4'hA);
    send(3'd0, 1'b0, 1'b0, 1'b0, 4'hC, 4'hA);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
